// File: rtl/axil_cmd_seq.sv
// -----------------------------------------------------------------------------
// axil_cmd_seq
//
// Command sequencer placed in front of the AXI4-Lite master's user port.
// Write/read commands are queued in a DEPTH-entry FIFO and issued to the
// master one at a time as single-cycle write/read pulses. The sequencer then
// waits for the matching completion pulse (or a TIMEOUT-cycle timeout) and
// presents the outcome on a valid/ready response port.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command push handshake
//   cmd_wr                   1 = write, 0 = read
//   cmd_addr, cmd_wdata      command word address / write data
//   write, read              one-cycle request pulses to the master
//   user_waddr, user_wdata   write address/data to the master (held until next issue)
//   user_raddr               read address to the master (held until next issue)
//   user_rdata               read data from the master, valid with rd_ready
//   wr_ready, rd_ready       completion pulses from the master
//   wr_error, rd_error       error flags, valid with the completion pulse
//   rsp_valid/rsp_ready      response handshake
//   rsp_wr                   response belongs to a write
//   rsp_rdata                read data (0 for writes, errors and timeouts)
//   rsp_err                  00 OK, 01 slave error, 10 timeout
//   fifo_count               occupied FIFO entries
//   busy                     FSM not idle or FIFO not empty
//   timeout_flag             sticky timeout indicator, cleared only by reset
// -----------------------------------------------------------------------------
module axil_cmd_seq #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_wr,
  input  logic [31:0]              cmd_addr,
  input  logic [31:0]              cmd_wdata,
  output logic                     write,
  output logic                     read,
  output logic [31:0]              user_waddr,
  output logic [31:0]              user_wdata,
  output logic [31:0]              user_raddr,
  input  logic [31:0]              user_rdata,
  input  logic                     wr_ready,
  input  logic                     rd_ready,
  input  logic                     wr_error,
  input  logic                     rd_error,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_wr,
  output logic [31:0]              rsp_rdata,
  output logic [1:0]               rsp_err,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     timeout_flag
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int ENT_W  = 1 + 2 * DATA_W;

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // Read data is only meaningful for a successful read; everything else
  // reports zero so the consumer never sees stale bus values.
  function automatic logic [DATA_W-1:0] rsp_data_sel(
    input logic              is_wr,
    input logic              err,
    input logic [DATA_W-1:0] data
  );
    return (!is_wr && !err) ? data : '0;
  endfunction

  state_t              state_q;
  state_t              state_d;

  logic [ENT_W-1:0]    mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [ENT_W-1:0]    head;
  logic                head_wr;
  logic [DATA_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;

  logic                push;
  logic                pop;
  logic                done;
  logic                tmo;
  logic                cur_wr_q;
  logic                cur_err;
  logic [TW-1:0]       timer_q;

  assign cmd_ready = (fifo_count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state_q != S_IDLE) || (fifo_count != '0);

  assign head      = mem[rd_ptr];
  assign head_wr   = head[ENT_W-1];
  assign head_addr = head[2*DATA_W-1:DATA_W];
  assign head_data = head[DATA_W-1:0];

  assign cur_err   = cur_wr_q ? wr_error : rd_error;

  // FIFO storage holds data only and needs no reset.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_wr, cmd_addr, cmd_wdata};
    end
  end

  // Next-state and pulse outputs.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    write     = 1'b0;
    read      = 1'b0;
    rsp_valid = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        write   = cur_wr_q;
        read    = !cur_wr_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Only the completion pulse matching the outstanding type counts;
        // it also takes priority over a timeout in the same cycle.
        done = cur_wr_q ? wr_ready : rd_ready;
        if (done) begin
          state_d = S_RESP;
        end else if (timer_q == TMO_LAST) begin
          tmo     = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, FIFO bookkeeping, command and response registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      timer_q      <= '0;
      cur_wr_q     <= 1'b0;
      timeout_flag <= 1'b0;
      user_waddr   <= '0;
      user_wdata   <= '0;
      user_raddr   <= '0;
      rsp_wr       <= 1'b0;
      rsp_err      <= '0;
      rsp_rdata    <= '0;
    end else begin
      state_q <= state_d;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      // Loading only the side that matches the command type keeps the other
      // address/data outputs stable across commands of the other type.
      if (pop) begin
        cur_wr_q <= head_wr;
        if (head_wr) begin
          user_waddr <= head_addr;
          user_wdata <= head_data;
        end else begin
          user_raddr <= head_addr;
        end
      end

      if (state_q == S_ISSUE) begin
        timer_q <= '0;
      end else if (state_q == S_WAIT && !done && !tmo) begin
        timer_q <= timer_q + 1'b1;
      end

      if (done) begin
        rsp_wr    <= cur_wr_q;
        rsp_err   <= {1'b0, cur_err};
        rsp_rdata <= rsp_data_sel(cur_wr_q, cur_err, user_rdata);
      end else if (tmo) begin
        rsp_wr       <= cur_wr_q;
        rsp_err      <= ERR_TIMEOUT;
        rsp_rdata    <= '0;
        timeout_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axil_cmd_seq.sv
`timescale 1ns/1ps
module tb_axil_cmd_seq;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int NRAND   = 40;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] rdata;
  } iss_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr = 1'b0;
  logic [31:0]   cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic          write;
  logic          read;
  logic [31:0]   user_waddr;
  logic [31:0]   user_wdata;
  logic [31:0]   user_raddr;
  logic [31:0]   user_rdata;
  logic          wr_ready;
  logic          rd_ready;
  logic          wr_error;
  logic          rd_error;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_wr;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_err;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          timeout_flag;

  // Master-side stimulus: directed tasks (t_*) or the automatic master (m_*).
  logic          auto_master = 1'b0;
  logic          t_wr_ready = 1'b0, t_rd_ready = 1'b0, t_wr_error = 1'b0, t_rd_error = 1'b0;
  logic [31:0]   t_rdata = '0;
  logic          m_wr_ready, m_rd_ready, m_wr_error, m_rd_error;
  logic [31:0]   m_rdata;

  assign wr_ready   = auto_master ? m_wr_ready : t_wr_ready;
  assign rd_ready   = auto_master ? m_rd_ready : t_rd_ready;
  assign wr_error   = auto_master ? m_wr_error : t_wr_error;
  assign rd_error   = auto_master ? m_rd_error : t_rd_error;
  assign user_rdata = auto_master ? m_rdata    : t_rdata;

  int   n_cmp  = 0;
  int   n_fail = 0;
  cmd_t cmd_q[$];
  iss_t iss_q[$];

  always #5 aclk = ~aclk;

  axil_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .write(write), .read(read),
    .user_waddr(user_waddr), .user_wdata(user_wdata), .user_raddr(user_raddr),
    .user_rdata(user_rdata), .wr_ready(wr_ready), .rd_ready(rd_ready),
    .wr_error(wr_error), .rd_error(rd_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .fifo_count(fifo_count), .busy(busy), .timeout_flag(timeout_flag)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Expected response for a command given how the master answered it.
  function automatic logic [34:0] model_rsp(cmd_t c, iss_t m);
    logic [31:0] d;
    d = (c.wr || m.err) ? 32'h0 : m.rdata;
    return {c.wr, 1'b0, m.err, d};
  endfunction

  // Automatic master: answers each request 1..4 cycles later with a random
  // error flag and read data, and records what it saw and what it returned.
  initial begin : master
    iss_t r;
    m_wr_ready = 1'b0; m_rd_ready = 1'b0; m_wr_error = 1'b0; m_rd_error = 1'b0;
    m_rdata = '0;
    forever begin
      step();
      if (auto_master && (write === 1'b1 || read === 1'b1)) begin
        r.wr    = write;
        r.addr  = write ? user_waddr : user_raddr;
        r.data  = write ? user_wdata : 32'h0;
        r.err   = ($urandom_range(0, 3) == 0);
        r.rdata = $urandom;
        repeat ($urandom_range(1, 4)) step();
        m_rdata = r.rdata;
        if (r.wr) begin
          m_wr_ready = 1'b1; m_wr_error = r.err;
        end else begin
          m_rd_ready = 1'b1; m_rd_error = r.err;
        end
        iss_q.push_back(r);
        step();
        m_wr_ready = 1'b0; m_rd_ready = 1'b0; m_wr_error = 1'b0; m_rd_error = 1'b0;
        m_rdata = $urandom;
      end
    end
  end

  task automatic test_reset();
    aresetn = 1'b0;
    step(); step();
    n_cmp++;
    if ({write, read, rsp_valid, busy, timeout_flag, rsp_wr} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got w/r/v/busy/tf/rwr=%b want 000000",
               {write, read, rsp_valid, busy, timeout_flag, rsp_wr});
    end
    n_cmp++;
    if (fifo_count !== '0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_fifo: got count=%0d ready=%b want 0/1", fifo_count, cmd_ready);
    end
    n_cmp++;
    if ({user_waddr, user_wdata, user_raddr, rsp_rdata, rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h %b want all 0",
               user_waddr, user_wdata, user_raddr, rsp_rdata, rsp_err);
    end
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h0000_A5A5;
    step();
    cmd_valid = 1'b0;
    n_cmp++;
    if (write !== 1'b0) begin
      n_fail++; $display("FAIL sw_early: write=%b one cycle after push, want 0", write);
    end
    step();
    n_cmp++;
    if ({write, read} !== 2'b10 || user_waddr !== 32'h0 || user_wdata !== 32'h0000_A5A5) begin
      n_fail++;
      $display("FAIL sw_issue: w/r=%b addr=%h data=%h want 10 0 0000a5a5",
               {write, read}, user_waddr, user_wdata);
    end
    step();
    n_cmp++;
    if (write !== 1'b0) begin
      n_fail++; $display("FAIL sw_pulse_len: write=%b after pulse, want 0", write);
    end
    step(); step(); step();
    t_wr_ready = 1'b1; t_wr_error = 1'b0; t_rdata = 32'hDEAD_BEEF;
    step();
    t_wr_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_wr, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL sw_rsp: v=%b wr=%b err=%b rdata=%h want 1 1 00 0",
               rsp_valid, rsp_wr, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL sw_rsp_drop: rsp_valid=%b after handshake, want 0", rsp_valid);
    end
  endtask

  task automatic test_read_error();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h200; cmd_wdata = 32'h1111_2222;
    step();
    cmd_valid = 1'b0;
    for (int w = 0; w < 10 && read !== 1'b1; w++) step();
    n_cmp++;
    if ({write, read} !== 2'b01 || user_raddr !== 32'h200) begin
      n_fail++;
      $display("FAIL re_issue: w/r=%b raddr=%h want 01 00000200", {write, read}, user_raddr);
    end
    step(); step();
    t_rd_ready = 1'b1; t_rd_error = 1'b1; t_rdata = 32'h0000_BEEF;
    step();
    t_rd_ready = 1'b0; t_rd_error = 1'b0;
    for (int h = 0; h < 3; h++) begin
      n_cmp++;
      if ({rsp_valid, rsp_wr, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 2'b01, 32'h0}) begin
        n_fail++;
        $display("FAIL re_hold%0d: v=%b wr=%b err=%b rdata=%h want 1 0 01 0",
                 h, rsp_valid, rsp_wr, rsp_err, rsp_rdata);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_wrong_pulse();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h44; cmd_wdata = 32'h0;
    step();
    cmd_valid = 1'b0;
    for (int w = 0; w < 10 && read !== 1'b1; w++) step();
    step();
    t_wr_ready = 1'b1; t_rdata = 32'hFFFF_0000;
    step();
    t_wr_ready = 1'b0;
    step();
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wp_ignored: rsp_valid=%b busy=%b after wr_ready on read, want 0 1",
               rsp_valid, busy);
    end
    t_rd_ready = 1'b1; t_rdata = 32'h1234;
    step();
    t_rd_ready = 1'b0; t_rdata = 32'h0;
    n_cmp++;
    if ({rsp_valid, rsp_wr, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 2'b00, 32'h1234}) begin
      n_fail++;
      $display("FAIL wp_rsp: v=%b wr=%b err=%b rdata=%h want 1 0 00 00001234",
               rsp_valid, rsp_wr, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    n_cmp++;
    if (timeout_flag !== 1'b0) begin
      n_fail++; $display("FAIL to_flag_pre: timeout_flag=%b want 0", timeout_flag);
    end
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h5;
    step();
    cmd_valid = 1'b0;
    step();
    n_cmp++;
    if (write !== 1'b1) begin
      n_fail++; $display("FAIL to_issue: write=%b want 1", write);
    end
    step();
    for (int i = 1; i < TIMEOUT; i++) begin
      step();
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL to_early: rsp_valid=%b at wait cycle %0d, want 0", rsp_valid, i);
      end
    end
    step();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, timeout_flag} !== {1'b1, 2'b10, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL to_rsp: v=%b err=%b rdata=%h tf=%b want 1 10 0 1",
               rsp_valid, rsp_err, rsp_rdata, timeout_flag);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    rd = $urandom;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h20; cmd_wdata = 32'h0;
    step();
    cmd_valid = 1'b0;
    for (int w = 0; w < 10 && read !== 1'b1; w++) step();
    step();
    t_rd_ready = 1'b1; t_rdata = rd;
    step();
    t_rd_ready = 1'b0; t_rdata = 32'h0;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, timeout_flag} !== {1'b1, 2'b00, rd, 1'b1}) begin
      n_fail++;
      $display("FAIL to_next_ok: v=%b err=%b rdata=%h tf=%b want 1 00 %h 1",
               rsp_valid, rsp_err, rsp_rdata, timeout_flag, rd);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_cmp++;
    if (timeout_flag !== 1'b1) begin
      n_fail++; $display("FAIL to_sticky: timeout_flag=%b want 1", timeout_flag);
    end
  endtask

  task automatic test_full_fifo();
    cmd_t c;
    iss_t m;
    auto_master = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      c.wr = 1'($urandom); c.addr = $urandom; c.data = $urandom;
      cmd_valid = 1'b1; cmd_wr = c.wr; cmd_addr = c.addr; cmd_wdata = c.data;
      if (cmd_ready === 1'b1) cmd_q.push_back(c);
      step();
    end
    cmd_valid = 1'b0;
    for (int w = 0; w < 20 && rsp_valid !== 1'b1; w++) step();
    n_cmp++;
    if (fifo_count !== CW'(DEPTH) || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ff_full: count=%0d ready=%b want %0d 0", fifo_count, cmd_ready, DEPTH);
    end
    for (int k = 0; k < DEPTH + 2; k++) begin
      for (int w = 0; w < 40 && rsp_valid !== 1'b1; w++) step();
      rsp_ready = 1'b1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || cmd_q.size() == 0 || iss_q.size() == 0) begin
        n_fail++;
        $display("FAIL ff_rsp%0d: rsp_valid=%b cmds=%0d issued=%0d want 1 and outstanding",
                 k, rsp_valid, cmd_q.size(), iss_q.size());
      end else begin
        c = cmd_q.pop_front();
        m = iss_q.pop_front();
        if ({m.wr, m.addr, m.data} !== {c.wr, c.addr, (c.wr ? c.data : 32'h0)}) begin
          n_fail++;
          $display("FAIL ff_issue%0d: got %b %h %h want %b %h %h",
                   k, m.wr, m.addr, m.data, c.wr, c.addr, c.data);
        end
        n_cmp++;
        if ({rsp_wr, rsp_err, rsp_rdata} !== model_rsp(c, m)) begin
          n_fail++;
          $display("FAIL ff_order%0d: got %h want %h", k, {rsp_wr, rsp_err, rsp_rdata}, model_rsp(c, m));
        end
      end
      step();
      rsp_ready = 1'b0;
      if (k == 0) begin
        step();
        n_cmp++;
        if (fifo_count !== CW'(DEPTH - 1) || cmd_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL ff_first_pop: count=%0d ready=%b want %0d 1", fifo_count, cmd_ready, DEPTH - 1);
        end
      end else if (k == 1) begin
        c.wr = 1'($urandom); c.addr = $urandom; c.data = $urandom;
        cmd_valid = 1'b1; cmd_wr = c.wr; cmd_addr = c.addr; cmd_wdata = c.data;
        if (cmd_ready === 1'b1) cmd_q.push_back(c);
        step();
        cmd_valid = 1'b0;
        n_cmp++;
        if (fifo_count !== CW'(DEPTH - 1)) begin
          n_fail++;
          $display("FAIL ff_push_pop: count=%0d want %0d", fifo_count, DEPTH - 1);
        end
      end
    end
    auto_master = 1'b0;
    cmd_q.delete();
    iss_q.delete();
  endtask

  task automatic test_random();
    cmd_t        c;
    iss_t        m;
    int          sent = 0;
    int          got  = 0;
    logic        hold = 1'b0;
    logic [34:0] held = '0;
    auto_master = 1'b1;
    for (int cyc = 0; cyc < 3000 && got < NRAND; cyc++) begin
      c.wr = 1'($urandom); c.addr = $urandom; c.data = $urandom;
      cmd_valid = (sent < NRAND) && ($urandom_range(0, 2) != 0);
      cmd_wr = c.wr; cmd_addr = c.addr; cmd_wdata = c.data;
      rsp_ready = 1'($urandom);
      n_cmp++;
      if (write === 1'b1 && read === 1'b1) begin
        n_fail++; $display("FAIL rnd_both: write and read both high at cycle %0d", cyc);
      end
      if (hold) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || {rsp_wr, rsp_err, rsp_rdata} !== held) begin
          n_fail++;
          $display("FAIL rnd_hold: v=%b rsp=%h want 1 %h", rsp_valid, {rsp_wr, rsp_err, rsp_rdata}, held);
        end
      end
      if (cmd_valid && cmd_ready === 1'b1) begin
        cmd_q.push_back(c);
        sent++;
      end
      hold = (rsp_valid === 1'b1) && !rsp_ready;
      held = {rsp_wr, rsp_err, rsp_rdata};
      if (rsp_valid === 1'b1 && rsp_ready) begin
        got++;
        n_cmp++;
        if (cmd_q.size() == 0 || iss_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_spurious: response with cmds=%0d issued=%0d", cmd_q.size(), iss_q.size());
        end else begin
          c = cmd_q.pop_front();
          m = iss_q.pop_front();
          if ({m.wr, m.addr, m.data} !== {c.wr, c.addr, (c.wr ? c.data : 32'h0)}) begin
            n_fail++;
            $display("FAIL rnd_issue%0d: got %b %h %h want %b %h %h",
                     got, m.wr, m.addr, m.data, c.wr, c.addr, c.data);
          end
          n_cmp++;
          if ({rsp_wr, rsp_err, rsp_rdata} !== model_rsp(c, m)) begin
            n_fail++;
            $display("FAIL rnd_rsp%0d: got %h want %h", got, {rsp_wr, rsp_err, rsp_rdata}, model_rsp(c, m));
          end
        end
      end
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    auto_master = 1'b0;
    n_cmp++;
    if (got !== NRAND || busy !== 1'b0) begin
      n_fail++; $display("FAIL rnd_done: responses=%0d busy=%b want %0d 0", got, busy, NRAND);
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'(i * 4); cmd_wdata = $urandom;
      step();
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (fifo_count !== CW'(3) || busy !== 1'b1) begin
      n_fail++; $display("FAIL rm_queued: count=%0d busy=%b want 3 1", fifo_count, busy);
    end
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if (fifo_count !== '0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rm_fifo: count=%0d ready=%b want 0 1", fifo_count, cmd_ready);
    end
    n_cmp++;
    if ({write, read, rsp_valid, busy, timeout_flag} !== 5'b0) begin
      n_fail++;
      $display("FAIL rm_ctrl: w/r/v/busy/tf=%b want 00000", {write, read, rsp_valid, busy, timeout_flag});
    end
    step(); step();
    aresetn = 1'b1;
    step(); step(); step();
    n_cmp++;
    if ({write, read, rsp_valid, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL rm_after: w/r/v/busy=%b want 0000 (dropped command reissued)",
               {write, read, rsp_valid, busy});
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    test_reset();
    test_single_write();
    test_read_error();
    test_wrong_pulse();
    test_timeout();
    test_full_fifo();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
